// File: rtl/executor_pkg.sv
// Shared constants, decode result payload and FSM state type for the executor_mc execute stage.
package executor_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CAUSE_W = 4;

  // opcode[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [CAUSE_W-1:0] CAUSE_INSN_MISALIGN  = 4'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_STORE_MISALIGN = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  result;
    logic [DATA_W-1:0]  pc_next;
    logic               taken;
    logic               exc;
    logic [CAUSE_W-1:0] cause;
    logic               rd_we;
  } exec_res_t;

endpackage

// File: rtl/executor_mc_lsu_lane.sv
// Store lane replication/strobe generation and load byte/halfword extract with sign/zero extension.
module lsu_lane
  import executor_pkg::*;
(
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] st_data,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] ld_word,
  output logic [DATA_W-1:0] wdata_c,
  output logic [STRB_W-1:0] wstrb_c,
  output logic [DATA_W-1:0] ld_data_c
);

  logic [DATA_W-1:0] ld_shift;

  // Strobes shift with the byte offset and fall off the top rather than wrap
  always_comb begin
    wdata_c = st_data;
    wstrb_c = 4'hF;
    case (st_funct3[1:0])
      2'b00: begin
        wdata_c = {4{st_data[7:0]}};
        wstrb_c = 4'(4'b0001 << st_off);
      end
      2'b01: begin
        wdata_c = {2{st_data[15:0]}};
        wstrb_c = 4'(4'b0011 << st_off);
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shift  = ld_word >> {ld_off, 3'b000};
    ld_data_c = ld_word;
    case (ld_funct3)
      F3_B:    ld_data_c = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_data_c = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_BU:   ld_data_c = {24'd0, ld_shift[7:0]};
      F3_HU:   ld_data_c = {16'd0, ld_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/executor_mc.sv
// Multi-cycle RV32I execute stage with one memory transaction per load/store.
// Define EXEC_MISALIGN_TRAP_EN to trap misaligned data accesses and jump targets.
module executor_mc
  import executor_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned C_EXT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              in_c_mode,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic              out_rd_we,
  output logic [XLEN-1:0]   out_rd_data,
  output logic [XLEN-1:0]   out_pc_next,
  output logic              out_br_taken,
  output logic              out_exc,
  output logic [3:0]        out_exc_cause
);

`ifdef EXEC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e state_q, state_d;
  exec_res_t ex;
  logic [4:0] opc;
  logic [XLEN-1:0] step, pc_inc, ea, op_b, alu, target;
  logic [4:0] shamt;
  logic br_cond, is_load, is_store, wb, illegal, size_mis, go_mem;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic [XLEN/8-1:0] st_wstrb;
  logic [2:0] ld_funct3_q, ld_funct3_d;
  logic [1:0] ld_off_q, ld_off_d;
  logic [4:0] out_rd_d;
  logic out_rd_we_d, out_br_taken_d, out_exc_d, mem_we_d;
  logic [XLEN-1:0] out_rd_data_d, out_pc_next_d, mem_wdata_d;
  logic [3:0] out_exc_cause_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [XLEN/8-1:0] mem_wstrb_d;
  logic unused_funct7;

  assign unused_funct7 = ^{in_funct7[6], in_funct7[4:0]};
  assign opc = in_opcode[6:2];

  lsu_lane u_lsu_lane (
    .st_funct3 (in_funct3),
    .st_off    (ea[1:0]),
    .st_data   (in_rs2),
    .ld_funct3 (ld_funct3_q),
    .ld_off    (ld_off_q),
    .ld_word   (mem_rsp_data),
    .wdata_c   (st_wdata),
    .wstrb_c   (st_wstrb),
    .ld_data_c (ld_data)
  );

  // ALU and branch comparator on the live issue operands
  always_comb begin
    step   = ((C_EXT != 0) && in_c_mode) ? XLEN'(2) : XLEN'(4);
    pc_inc = in_pc + step;
    ea     = in_rs1 + in_imm;
    op_b   = (opc == OPC_OP) ? in_rs2 : in_imm;
    shamt  = op_b[4:0];
    case (in_funct3)
      F3_ADD:  alu = (opc == OPC_OP && in_funct7[5]) ? in_rs1 - op_b : in_rs1 + op_b;
      F3_SLL:  alu = in_rs1 << shamt;
      F3_SLT:  alu = XLEN'($signed(in_rs1) < $signed(op_b));
      F3_SLTU: alu = XLEN'(in_rs1 < op_b);
      F3_XOR:  alu = in_rs1 ^ op_b;
      F3_SR:   alu = in_funct7[5] ? XLEN'($signed(in_rs1) >>> shamt) : in_rs1 >> shamt;
      F3_OR:   alu = in_rs1 | op_b;
      default: alu = in_rs1 & op_b;
    endcase
    case (in_funct3)
      F3_BEQ:  br_cond = (in_rs1 == in_rs2);
      F3_BNE:  br_cond = (in_rs1 != in_rs2);
      F3_BLT:  br_cond = ($signed(in_rs1) < $signed(in_rs2));
      F3_BGE:  br_cond = ($signed(in_rs1) >= $signed(in_rs2));
      F3_BLTU: br_cond = (in_rs1 < in_rs2);
      F3_BGEU: br_cond = (in_rs1 >= in_rs2);
      default: br_cond = 1'b0;
    endcase
  end

  // Opcode decode into the registered result payload
  always_comb begin
    ex         = '0;
    ex.pc_next = pc_inc;
    ex.result  = alu;
    is_load    = 1'b0;
    is_store   = 1'b0;
    wb         = 1'b0;
    illegal    = (in_opcode[1:0] != 2'b11);
    target     = in_pc + in_imm;
    case (opc)
      OPC_LUI:   begin ex.result = in_imm; wb = 1'b1; end
      OPC_AUIPC: begin ex.result = in_pc + in_imm; wb = 1'b1; end
      OPC_JAL:   begin ex.result = pc_inc; wb = 1'b1; ex.taken = 1'b1; end
      OPC_JALR: begin
        ex.result = pc_inc;
        wb        = 1'b1;
        ex.taken  = 1'b1;
        target    = ea & ~XLEN'(1);
        if (in_funct3 != 3'd0) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        ex.taken = br_cond;
        if (in_funct3 == 3'd2 || in_funct3 == 3'd3) illegal = 1'b1;
      end
      OPC_LOAD: begin
        is_load = 1'b1;
        wb      = 1'b1;
        if (!(in_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) illegal = 1'b1;
      end
      OPC_STORE: begin
        is_store = 1'b1;
        if (in_funct3[2] || in_funct3[1:0] == 2'b11) illegal = 1'b1;
      end
      OPC_OP_IMM, OPC_OP: wb = 1'b1;
      default: illegal = 1'b1;
    endcase
    size_mis = (in_funct3[1:0] == 2'b01 && ea[0]) || (in_funct3[1:0] == 2'b10 && ea[1:0] != 2'b00);
    if (illegal) begin
      ex.exc   = 1'b1;
      ex.cause = CAUSE_ILLEGAL;
      ex.taken = 1'b0;
    end else if (TRAP_EN && (is_load || is_store) && size_mis) begin
      ex.exc   = 1'b1;
      ex.cause = is_load ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
    end else if (TRAP_EN && (C_EXT == 0) && ex.taken && target[1]) begin
      ex.exc   = 1'b1;
      ex.cause = CAUSE_INSN_MISALIGN;
    end
    if (ex.taken) ex.pc_next = target;
    ex.rd_we = wb && (in_rd != 5'd0) && !ex.exc;
    go_mem   = (is_load || is_store) && !ex.exc;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d         = state_q;
    out_rd_d        = out_rd;
    out_rd_we_d     = out_rd_we;
    out_rd_data_d   = out_rd_data;
    out_pc_next_d   = out_pc_next;
    out_br_taken_d  = out_br_taken;
    out_exc_d       = out_exc;
    out_exc_cause_d = out_exc_cause;
    mem_addr_d      = mem_addr;
    mem_we_d        = mem_we;
    mem_wdata_d     = mem_wdata;
    mem_wstrb_d     = mem_wstrb;
    ld_funct3_d     = ld_funct3_q;
    ld_off_d        = ld_off_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          out_rd_d        = in_rd;
          out_rd_we_d     = ex.rd_we;
          out_rd_data_d   = ex.result;
          out_pc_next_d   = ex.pc_next;
          out_br_taken_d  = ex.taken;
          out_exc_d       = ex.exc;
          out_exc_cause_d = ex.cause;
          mem_addr_d      = ea[ADDR_W-1:0];
          mem_we_d        = is_store;
          mem_wdata_d     = st_wdata;
          mem_wstrb_d     = st_wstrb;
          ld_funct3_d     = in_funct3;
          ld_off_d        = ea[1:0];
          state_d         = go_mem ? ST_MEM_REQ : ST_RESP;
        end
      end
      ST_MEM_REQ: if (mem_req_ready) state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = ST_RESP;
          if (!mem_we) out_rd_data_d = ld_data;
        end
      end
      ST_RESP: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      mem_req_valid <= 1'b0;
      out_rd        <= '0;
      out_rd_we     <= 1'b0;
      out_rd_data   <= '0;
      out_pc_next   <= '0;
      out_br_taken  <= 1'b0;
      out_exc       <= 1'b0;
      out_exc_cause <= '0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      ld_funct3_q   <= '0;
      ld_off_q      <= '0;
    end else begin
      state_q       <= state_d;
      in_ready      <= (state_d == ST_IDLE);
      out_valid     <= (state_d == ST_RESP);
      mem_req_valid <= (state_d == ST_MEM_REQ);
      out_rd        <= out_rd_d;
      out_rd_we     <= out_rd_we_d;
      out_rd_data   <= out_rd_data_d;
      out_pc_next   <= out_pc_next_d;
      out_br_taken  <= out_br_taken_d;
      out_exc       <= out_exc_d;
      out_exc_cause <= out_exc_cause_d;
      mem_addr      <= mem_addr_d;
      mem_we        <= mem_we_d;
      mem_wdata     <= mem_wdata_d;
      mem_wstrb     <= mem_wstrb_d;
      ld_funct3_q   <= ld_funct3_d;
      ld_off_q      <= ld_off_d;
    end
  end

endmodule

// File: tb/tb_executor_mc.sv
// Scoreboard bench for executor_mc: expected results queued at issue, compared at out_valid.
module tb_executor_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic in_valid, in_ready, in_c_mode;
  logic [6:0] in_opcode, in_funct7;
  logic [2:0] in_funct3;
  logic [4:0] in_rd;
  logic [31:0] in_imm, in_rs1, in_rs2, in_pc;
  logic mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
  logic [3:0] mem_wstrb;
  logic out_valid, out_ready, out_rd_we, out_br_taken, out_exc;
  logic [4:0] out_rd;
  logic [31:0] out_rd_data, out_pc_next;
  logic [3:0] out_exc_cause;

  executor_mc dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .in_c_mode(in_c_mode),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_rd_data(out_rd_data),
    .out_pc_next(out_pc_next), .out_br_taken(out_br_taken),
    .out_exc(out_exc), .out_exc_cause(out_exc_cause)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        we;
    logic [31:0] nxt;
    logic        tk;
    logic        exc;
    logic [3:0]  cause;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic cm,
                       input logic [31:0] data, input logic chk, input logic we,
                       input logic [31:0] nxt, input logic tk, input logic exc,
                       input logic [3:0] cause);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check("in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7 = f7; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc; in_c_mode = cm;
    e.rd = rd; e.data = data; e.chk_data = chk; e.we = we; e.nxt = nxt;
    e.tk = tk; e.exc = exc; e.cause = cause;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold);
    exp_t e;
    int lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    check("out_latency", 32'(lat), 32'd0);
    if (exp_q.size() == 0) begin
      check("sb_nonempty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    check("rd", 32'(out_rd), 32'(e.rd));
    check("rd_we", 32'(out_rd_we), 32'(e.we));
    if (e.chk_data) check("rd_data", out_rd_data, e.data);
    check("pc_next", out_pc_next, e.nxt);
    check("br_taken", 32'(out_br_taken), 32'(e.tk));
    check("exc", 32'(out_exc), 32'(e.exc));
    check("exc_cause", 32'(out_exc_cause), 32'(e.cause));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_drop", 32'(out_valid), 32'd0);
  endtask

  task automatic mem_serve(input logic [31:0] addr, input logic we, input logic [3:0] strb,
                           input logic [31:0] wdata, input int delay, input logic [31:0] rsp,
                           input bit respond);
    int n = 0;
    while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
    check("req_valid", 32'(mem_req_valid), 32'd1);
    check("req_addr", mem_addr, addr);
    check("req_we", 32'(mem_we), 32'(we));
    if (we) begin
      check("req_wstrb", 32'(mem_wstrb), 32'(strb));
      check("req_wdata", mem_wdata, wdata);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("req_hold_valid", 32'(mem_req_valid), 32'd1);
      check("req_hold_addr", mem_addr, addr);
      if (we) check("req_hold_wdata", mem_wdata, wdata);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("req_drop", 32'(mem_req_valid), 32'd0);
    if (respond) begin
      @(negedge clk);
      mem_rsp_valid = 1'b1; mem_rsp_data = rsp;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
  endtask

  task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic cm,
                        input logic [31:0] data, input logic chk, input logic we,
                        input logic [31:0] nxt, input logic tk, input logic exc,
                        input logic [3:0] cause);
    issue(opc, f3, f7, rd, rs1, rs2, imm, pc, cm, data, chk, we, nxt, tk, exc, cause);
    wait_result(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_c_mode = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_rd_data", out_rd_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU, upper-immediate, jumps, branches, illegal encodings
    run_op(7'h13, 3'd0, 7'h00, 5'd5, 32'h10, 32'h0, 32'hFFFF_FFFF, 32'h100, 1'b0,
           32'h0F, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'd0);
    run_op(7'h63, 3'd4, 7'h00, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h100, 1'b0,
           32'h0, 1'b0, 1'b0, 32'h120, 1'b1, 1'b0, 4'd0);
    run_op(7'h63, 3'd6, 7'h00, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h100, 1'b0,
           32'h0, 1'b0, 1'b0, 32'h104, 1'b0, 1'b0, 4'd0);
    run_op(7'h63, 3'd0, 7'h00, 5'd0, 32'h7, 32'h7, 32'hFFFF_FFF8, 32'h100, 1'b0,
           32'h0, 1'b0, 1'b0, 32'hF8, 1'b1, 1'b0, 4'd0);
    run_op(7'h33, 3'd0, 7'h20, 5'd3, 32'h5, 32'h7, 32'h0, 32'h100, 1'b0,
           32'hFFFF_FFFE, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'd0);
    run_op(7'h33, 3'd5, 7'h20, 5'd3, 32'h8000_0000, 32'h4, 32'h0, 32'h100, 1'b0,
           32'hF800_0000, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'd0);
    run_op(7'h33, 3'd5, 7'h00, 5'd3, 32'h8000_0000, 32'h4, 32'h0, 32'h100, 1'b0,
           32'h0800_0000, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'd0);
    run_op(7'h33, 3'd3, 7'h00, 5'd6, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h100, 1'b0,
           32'h1, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'd0);
    run_op(7'h13, 3'd1, 7'h00, 5'd6, 32'h1, 32'h0, 32'd31, 32'h100, 1'b0,
           32'h8000_0000, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'd0);
    run_op(7'h13, 3'd4, 7'h00, 5'd8, 32'hFF00_FF00, 32'h0, 32'hFFFF_FFFF, 32'h100, 1'b0,
           32'h00FF_00FF, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'd0);
    run_op(7'h37, 3'd0, 7'h00, 5'd9, 32'h0, 32'h0, 32'h1234_5000, 32'h100, 1'b0,
           32'h1234_5000, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'd0);
    run_op(7'h17, 3'd0, 7'h00, 5'd9, 32'h0, 32'h0, 32'h1000, 32'h100, 1'b0,
           32'h1100, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'd0);
    run_op(7'h6F, 3'd0, 7'h00, 5'd1, 32'h0, 32'h0, 32'h40, 32'h200, 1'b1,
           32'h202, 1'b1, 1'b1, 32'h240, 1'b1, 1'b0, 4'd0);
    run_op(7'h67, 3'd0, 7'h00, 5'd1, 32'h301, 32'h0, 32'h0, 32'h200, 1'b0,
           32'h204, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 4'd0);
    run_op(7'h13, 3'd0, 7'h00, 5'd0, 32'h0, 32'h0, 32'h5, 32'h100, 1'b0,
           32'h5, 1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 4'd0);
    run_op(7'h7F, 3'd0, 7'h00, 5'd4, 32'h0, 32'h0, 32'h0, 32'h100, 1'b0,
           32'h0, 1'b0, 1'b0, 32'h104, 1'b0, 1'b1, 4'd2);
    run_op(7'h63, 3'd2, 7'h00, 5'd0, 32'h1, 32'h1, 32'h20, 32'h100, 1'b0,
           32'h0, 1'b0, 1'b0, 32'h104, 1'b0, 1'b1, 4'd2);

    // SB with a slow memory and a stalled result consumer
    issue(7'h23, 3'd0, 7'h00, 5'd0, 32'h1000, 32'hAB, 32'h3, 32'h400, 1'b0,
          32'h0, 1'b0, 1'b0, 32'h404, 1'b0, 1'b0, 4'd0);
    mem_serve(32'h1003, 1'b1, 4'b1000, 32'hABAB_ABAB, 3, 32'h0, 1'b1);
    wait_result(2);

    // LH / LHU upper halfword
    issue(7'h03, 3'd1, 7'h00, 5'd4, 32'h2000, 32'h0, 32'h2, 32'h400, 1'b0,
          32'hFFFF_8001, 1'b1, 1'b1, 32'h404, 1'b0, 1'b0, 4'd0);
    mem_serve(32'h2002, 1'b0, 4'h0, 32'h0, 0, 32'h8001_0000, 1'b1);
    wait_result(0);
    issue(7'h03, 3'd5, 7'h00, 5'd4, 32'h2000, 32'h0, 32'h2, 32'h400, 1'b0,
          32'h0000_8001, 1'b1, 1'b1, 32'h404, 1'b0, 1'b0, 4'd0);
    mem_serve(32'h2002, 1'b0, 4'h0, 32'h0, 1, 32'h8001_0000, 1'b1);
    wait_result(0);

    // Misaligned LW
`ifdef EXEC_MISALIGN_TRAP_EN
    issue(7'h03, 3'd2, 7'h00, 5'd7, 32'h2000, 32'h0, 32'h1, 32'h400, 1'b0,
          32'h0, 1'b0, 1'b0, 32'h404, 1'b0, 1'b1, 4'd4);
    check("mis_no_req", 32'(mem_req_valid), 32'd0);
    wait_result(0);
`else
    issue(7'h03, 3'd2, 7'h00, 5'd7, 32'h2000, 32'h0, 32'h1, 32'h400, 1'b0,
          32'h1122_3344, 1'b1, 1'b1, 32'h404, 1'b0, 1'b0, 4'd0);
    mem_serve(32'h2001, 1'b0, 4'h0, 32'h0, 0, 32'h1122_3344, 1'b1);
    wait_result(0);
`endif

    // Reset while waiting for a load response; late response must be dropped
    issue(7'h03, 3'd2, 7'h00, 5'd9, 32'h3000, 32'h0, 32'h0, 32'h500, 1'b0,
          32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    mem_serve(32'h3000, 1'b0, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
    end
    run_op(7'h13, 3'd0, 7'h00, 5'd5, 32'h10, 32'h0, 32'hFFFF_FFFF, 32'h100, 1'b0,
           32'h0F, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
